branch_predictor_bht: RTL and testbench
=======================================

// Module: branch_predictor_bht
// PURPOSE
//  Parametrised branch history table: 2^INDEX_BITS saturating counters replace the
//  single global 2-bit tracker. Optional gshare mode XORs a global history register into
//  the index. Fetch issues a same-cycle lookup; the resolve stage issues one update per
//  resolved conditional branch. Convention: 1 = taken, 0 = not taken.
// PARAMETERS
//  ADDR_W     64  width of the PC inputs
//  INDEX_BITS 4   table has 2^INDEX_BITS entries; base index = pc[INDEX_BITS+1:2]
//  CTR_BITS   2   counter width, 2..4; predict taken when counter MSB = 1
//  HIST_BITS  4   global history length, 1..INDEX_BITS; only used when GSHARE=1
//  GSHARE     0   0 = bimodal index; 1 = index = pc[INDEX_BITS+1:2] ^ zero-extended ghr
// PORTS
//  clk         in   1           rising-edge clock
//  reset       in   1           synchronous, active-high
//  lookup_pc   in   ADDR_W      PC of the instruction being fetched
//  pred        out  1           prediction for lookup_pc, combinational
//  pred_idx    out  INDEX_BITS  table index used for lookup_pc; carried down the pipe
//  upd_en      in   1           one resolved conditional branch this cycle
//  upd_idx     in   INDEX_BITS  pred_idx captured at fetch for that branch
//  upd_taken   in   1           actual outcome
//  upd_mispred in   1           prediction was wrong; qualified by upd_en
//  ghr         out  HIST_BITS   global history register, newest outcome in bit 0
//  mispred_cnt out  16          saturating count of mispredictions since reset
// BEHAVIOUR
//  - Reset (sync, high) for one clk edge: every counter = weakly not-taken
//    (MSB 0, all other bits 1, i.e. 01 for CTR_BITS=2); ghr = 0; mispred_cnt = 0.
//    After the reset edge, pred = 0 for every PC. Reset overrides a same-cycle update.
//  - Lookup: zero latency. pred = table[pred_idx][CTR_BITS-1]; pred_idx formed from
//    lookup_pc (and ghr when GSHARE=1). PC bits [1:0] and bits above the index are ignored.
//  - Update: on the clk edge with upd_en=1, table[upd_idx] +1 if upd_taken, else -1.
//    Saturates at 2^CTR_BITS-1 and at 0; no wrap-around.
//  - upd_en=0: table, ghr and mispred_cnt hold; upd_idx, upd_taken, upd_mispred ignored.
//  - ghr: on upd_en, ghr <= {ghr[HIST_BITS-2:0], upd_taken} (ghr <= upd_taken when
//    HIST_BITS=1). Non-speculative, updated only at resolve. Present and updated in
//    bimodal mode too.
//  - mispred_cnt: +1 on each edge with upd_en & upd_mispred; holds at 16'hFFFF.
//  - Lookup and update of the same index in one cycle: pred uses the pre-update value;
//    the new value is visible from the next cycle. No bypass.
//  - In gshare mode, a same-cycle lookup indexes with the pre-update ghr.
//  - One update port only; multiple branches resolving in one cycle are not supported.
//  - Storage is a flop array cleared by reset; no RAM macro, no reset-less entries.
// TESTING
//  1 reset, then lookup PCs 0x0..0x3C step 4 -> pred=0 for all; ghr=0; mispred_cnt=0.
//  2 bimodal, idx 3: 3 updates taken -> counter 01->10->11->11 (saturates);
//    pred for PC 0x0C =1 from 1st post-update cycle; 2 not-taken -> 01, pred=0.
//  3 idx 5: 4 updates not-taken from reset -> counter stays 00, no underflow;
//    neighbouring idx 4 and 6 unchanged at 01.
//  4 same cycle lookup PC 0x1C + update idx 7 taken (counter 01) -> pred=0 that cycle,
//    pred=1 next cycle.
//  5 GSHARE=1, HIST_BITS=4: outcomes T,T,N,T -> ghr=4'b1101; lookup PC 0x08 ->
//    pred_idx=4'b0010^4'b1101=4'b1111.
//  6 70000 updates with upd_mispred=1 -> mispred_cnt=16'hFFFF and holds; a mid-sequence
//    reset -> table, ghr, mispred_cnt back to reset values next cycle despite upd_en=1.

Source files
------------

// File: rtl/branch_predictor_bht.sv
// Branch history table of saturating counters, bimodal or gshare indexed; one resolve-time update port.
// Latency: lookup is combinational (same cycle); an update becomes visible on the cycle after its clk edge.
// Backpressure: none; one lookup and at most one update are accepted every cycle.
module branch_predictor_bht #(
  parameter int ADDR_W     = 64,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int HIST_BITS  = 4,
  parameter bit GSHARE     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     lookup_pc,
  output logic                  pred,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_en,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_mispred,
  output logic [HIST_BITS-1:0]  ghr,
  output logic [15:0]           mispred_cnt
);

  localparam int ENTRIES = 1 << INDEX_BITS;
  // Weakly not-taken: MSB clear, every lower bit set.
  localparam logic [CTR_BITS-1:0] CTR_RST = {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [CTR_BITS-1:0] CTR_MAX = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_MIN = {CTR_BITS{1'b0}};

  logic [CTR_BITS-1:0]   ctr_q [ENTRIES];
  logic [CTR_BITS-1:0]   ctr_cur;
  logic [CTR_BITS-1:0]   ctr_nxt;
  logic [INDEX_BITS-1:0] base_idx;
  logic [INDEX_BITS-1:0] hist_ext;
  logic [HIST_BITS-1:0]  ghr_nxt;
  logic                  unused_pc_bits;

  // Only the word-aligned index bits of the PC take part in the lookup.
  assign base_idx       = lookup_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[ADDR_W-1:INDEX_BITS+2], lookup_pc[1:0]};
  assign hist_ext       = INDEX_BITS'(ghr);

  // Lookup reads the registered table and ghr, so a same-cycle update is never bypassed.
  assign pred_idx = GSHARE ? (base_idx ^ hist_ext) : base_idx;
  assign pred     = ctr_q[pred_idx][CTR_BITS-1];

  // Saturating step of the counter being resolved.
  always_comb begin
    ctr_cur = ctr_q[upd_idx];
    ctr_nxt = ctr_cur;
    if (upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_nxt = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != CTR_MIN) ctr_nxt = ctr_cur - 1'b1;
    end
  end

  // Newest resolved outcome shifts into bit 0.
  generate
    if (HIST_BITS == 1) begin : g_hist1
      assign ghr_nxt = upd_taken;
    end else begin : g_histn
      assign ghr_nxt = {ghr[HIST_BITS-2:0], upd_taken};
    end
  endgenerate

  // Table, history and mispredict counter; reset wins over a same-cycle update.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= CTR_RST;
      ghr         <= '0;
      mispred_cnt <= '0;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_nxt;
      ghr            <= ghr_nxt;
      if (upd_mispred && (mispred_cnt != 16'hFFFF)) mispred_cnt <= mispred_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht: bimodal and gshare instances driven in parallel.
// Latency: compares combinational lookup every cycle against a plain-arithmetic model.
// Backpressure: none; stimulus advances one cycle per step.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] lookup_pc;
  logic        upd_en;
  logic [3:0]  upd_idx;
  logic        upd_taken;
  logic        upd_mispred;

  logic        b_pred, g_pred;
  logic [3:0]  b_pred_idx, g_pred_idx;
  logic [3:0]  b_ghr, g_ghr;
  logic [15:0] b_cnt, g_cnt;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: counter values as integers 0..3, history as integer 0..15.
  int m_ctr [16];
  int m_ghr;
  int m_cnt;

  always #5 clk = ~clk;

  branch_predictor_bht #(.ADDR_W(64), .INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .GSHARE(1'b0)) u_bim (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred(b_pred), .pred_idx(b_pred_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .ghr(b_ghr), .mispred_cnt(b_cnt)
  );

  branch_predictor_bht #(.ADDR_W(64), .INDEX_BITS(4), .CTR_BITS(2), .HIST_BITS(4), .GSHARE(1'b1)) u_gsh (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred(g_pred), .pred_idx(g_pred_idx),
    .upd_en(upd_en), .upd_idx(upd_idx), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
    .ghr(g_ghr), .mispred_cnt(g_cnt)
  );

  task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int base_of(input logic [63:0] pc);
    return int'((pc / 4) % 16);
  endfunction

  // Model: behavioural update on each rising edge.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_ctr[i] = 1;
      m_ghr = 0;
      m_cnt = 0;
    end else if (upd_en) begin
      if (upd_taken) m_ctr[upd_idx] = (m_ctr[upd_idx] == 3) ? 3 : m_ctr[upd_idx] + 1;
      else           m_ctr[upd_idx] = (m_ctr[upd_idx] == 0) ? 0 : m_ctr[upd_idx] - 1;
      m_ghr = ((m_ghr * 2) + (upd_taken ? 1 : 0)) % 16;
      if (upd_mispred && m_cnt < 65535) m_cnt = m_cnt + 1;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      int bi, gi;
      bi = base_of(lookup_pc);
      gi = bi ^ m_ghr;
      check("bim_pred_idx", b_pred_idx, bi);
      check("bim_pred",     b_pred,     (m_ctr[bi] >= 2) ? 1 : 0);
      check("bim_ghr",      b_ghr,      m_ghr);
      check("bim_cnt",      b_cnt,      m_cnt);
      check("gsh_pred_idx", g_pred_idx, gi);
      check("gsh_pred",     g_pred,     (m_ctr[gi] >= 2) ? 1 : 0);
      check("gsh_ghr",      g_ghr,      m_ghr);
      check("gsh_cnt",      g_cnt,      m_cnt);
    end
  end

  task automatic set_in(input logic [63:0] pc, input logic en, input logic [3:0] idx,
                        input logic tk, input logic mp);
    lookup_pc   = pc;
    upd_en      = en;
    upd_idx     = idx;
    upd_taken   = tk;
    upd_mispred = mp;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_in(64'h0, 1'b0, 4'h0, 1'b0, 1'b0);
    tick();
    reset  = 1'b0;
    chk_en = 1'b1;

    // 1: reset state, every PC predicts not-taken
    #1;
    check("rst_ghr", b_ghr, 0);
    check("rst_cnt", b_cnt, 0);
    check("rst_gsh_cnt", g_cnt, 0);
    for (int p = 0; p <= 'h3C; p += 4) begin
      set_in(64'(p), 1'b0, 4'h0, 1'b0, 1'b0);
      #1;
      check("rst_pred", b_pred, 0);
      tick();
    end

    // 2: idx 3 trained taken to saturation, then back to weakly not-taken
    do_reset();
    set_in(64'h0C, 1'b1, 4'd3, 1'b1, 1'b0);
    tick();
    #1;
    check("t2_pred_after_first", b_pred, 1);
    tick();
    tick();
    set_in(64'h0C, 1'b1, 4'd3, 1'b0, 1'b1);
    tick();
    #1;
    check("t2_pred_at_10", b_pred, 1);
    tick();
    set_in(64'h0C, 1'b0, 4'd3, 1'b0, 1'b0);
    #1;
    check("t2_pred_back_01", b_pred, 0);
    check("t2_mispred_cnt", b_cnt, 2);
    tick();

    // 3: idx 5 underflow guard, neighbours untouched
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_in(64'h14, 1'b1, 4'd5, 1'b0, 1'b0);
      tick();
    end
    // one taken step from 00 must give 01 (pred 0), from a wrapped value it would differ
    set_in(64'h14, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    set_in(64'h14, 1'b1, 4'd5, 1'b1, 1'b0);
    tick();
    set_in(64'h14, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("t3_idx5_after_2T", b_pred, 1);
    tick();
    for (int p = 'h10; p <= 'h18; p += 4) begin
      set_in(64'(p), 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
    end

    // 4: same-cycle lookup and update of idx 7, no bypass
    do_reset();
    set_in(64'h1C, 1'b1, 4'd7, 1'b1, 1'b0);
    #1;
    check("t4_pred_same_cycle", b_pred, 0);
    tick();
    set_in(64'h1C, 1'b0, 4'd7, 1'b0, 1'b0);
    #1;
    check("t4_pred_next_cycle", b_pred, 1);
    tick();

    // 5: gshare history T,T,N,T then lookup PC 0x08
    do_reset();
    set_in(64'h0, 1'b1, 4'd0, 1'b1, 1'b0); tick();
    set_in(64'h0, 1'b1, 4'd0, 1'b1, 1'b0); tick();
    set_in(64'h0, 1'b1, 4'd0, 1'b0, 1'b0); tick();
    set_in(64'h0, 1'b1, 4'd0, 1'b1, 1'b0); tick();
    set_in(64'h08, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("t5_ghr", g_ghr, 4'b1101);
    check("t5_gsh_pred_idx", g_pred_idx, 4'b1111);
    check("t5_bim_pred_idx", b_pred_idx, 4'b0010);
    check("t5_bim_ghr", b_ghr, 4'b1101);
    tick();
    // upper and low PC bits are ignored
    set_in(64'hFFFF_0000_0000_000B, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("t5_pc_hi_ignored", b_pred_idx, 4'b0010);
    tick();

    // 6: mispredict counter saturation, then reset overriding an update
    do_reset();
    for (int n = 0; n < 65540; n++) begin
      set_in(64'((n % 16) * 4), 1'b1, 4'(n % 16), n[0], 1'b1);
      tick();
    end
    check("t6_cnt_sat", b_cnt, 16'hFFFF);
    set_in(64'h0, 1'b1, 4'd0, 1'b1, 1'b1);
    tick();
    check("t6_cnt_hold", b_cnt, 16'hFFFF);
    reset = 1'b1;
    set_in(64'h0, 1'b1, 4'd2, 1'b1, 1'b1);
    tick();
    reset = 1'b0;
    set_in(64'h08, 1'b0, 4'd0, 1'b0, 1'b0);
    #1;
    check("t6_rst_cnt", b_cnt, 0);
    check("t6_rst_ghr", g_ghr, 0);
    check("t6_rst_pred_idx2", b_pred, 0);
    tick();
    for (int p = 0; p <= 'h3C; p += 4) begin
      set_in(64'(p), 1'b0, 4'h0, 1'b0, 1'b0);
      tick();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
